line_drive_sequencer: RTL and testbench

- Upstream stage that feeds the two servo PWM generators (left and right wheel).
- Owns the 20 ms servo frame timebase: supplies the shared count value and a per-frame restart pulse to both PWM generators.
- Turns three line sensors into a left/right direction code, using synchronisation, debounce and a steering state machine.
- Direction codes change only at frame boundaries, so no PWM pulse is ever cut short.

---
 rtl/line_drive_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_line_drive_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_drive_sequencer.sv
// Line-following front end for the two wheel PWM generators.
// Owns the servo frame timebase, cleans up the three line sensors
// (two-flop synchroniser plus debounce), and steers through a small FSM
// whose state changes only at frame wraps, so no PWM pulse is ever cut short.
module line_drive_sequencer #(
    parameter int unsigned PERIOD      = 2000000,
    parameter int unsigned CNT_W       = 21,
    parameter int unsigned DEBOUNCE    = 50000,
    parameter int unsigned LOST_FRAMES = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sensor_l,
    input  logic             sensor_m,
    input  logic             sensor_r,
    output logic [CNT_W-1:0] count_out,
    output logic             motor_reset,
    output logic [1:0]       direction_l,
    output logic [1:0]       direction_r,
    output logic             frame_start
);

    localparam int unsigned DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int unsigned LOST_W = $clog2(LOST_FRAMES + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_FRAMES);

    localparam logic [2:0] ST_STOP   = 3'd0;
    localparam logic [2:0] ST_FWD    = 3'd1;
    localparam logic [2:0] ST_SOFT_L = 3'd2;
    localparam logic [2:0] ST_HARD_L = 3'd3;
    localparam logic [2:0] ST_SOFT_R = 3'd4;
    localparam logic [2:0] ST_HARD_R = 3'd5;

    // Wheel codes; the left wheel is mirror-mounted, so "forward" is ccw there.
    localparam logic [1:0] DIR_STOP = 2'b00;
    localparam logic [1:0] DIR_CW   = 2'b01;
    localparam logic [1:0] DIR_CCW  = 2'b10;

    logic [CNT_W-1:0]  r_count;
    logic              r_frame_start;
    logic [2:0]        r_sync1;
    logic [2:0]        r_sync2;
    logic [2:0]        r_prev;
    logic [2:0]        r_sensed;
    logic [DB_W-1:0]   r_db_cnt;
    logic [2:0]        r_state;
    logic [LOST_W-1:0] r_lost;
    logic [1:0]        r_dir_l;
    logic [1:0]        r_dir_r;

    logic              w_wrap;
    logic              w_changed;
    logic [DB_W-1:0]   w_db_cnt_next;
    logic [2:0]        w_state_next;
    logic [LOST_W-1:0] w_lost_next;
    logic [1:0]        w_dir_l_next;
    logic [1:0]        w_dir_r_next;

    assign w_wrap      = (r_count == CNT_LAST);
    assign w_changed   = (r_sync2 != r_prev);

    assign count_out   = r_count;
    assign frame_start = r_frame_start;
    assign direction_l = r_dir_l;
    assign direction_r = r_dir_r;
    // Restart pulse lands on the last count so the PWM generators are off as count hits 0.
    assign motor_reset = reset | w_wrap;

    // Frame counter and the registered frame-start pulse (absent in the first frame).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_count       <= w_wrap ? '0 : r_count + CNT_W'(1);
            r_frame_start <= w_wrap;
        end
    end

    // Debounce counter: restarts on any change, saturates once the vector is accepted.
    always_comb begin
        if (w_changed) begin
            w_db_cnt_next = '0;
        end else if (r_db_cnt == DB_LAST) begin
            w_db_cnt_next = r_db_cnt;
        end else begin
            w_db_cnt_next = r_db_cnt + DB_W'(1);
        end
    end

    // Synchroniser chain, change detector and accepted sensor vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_prev   <= '0;
            r_db_cnt <= '0;
            r_sensed <= '0;
        end else begin
            r_sync1  <= {sensor_l, sensor_m, sensor_r};
            r_sync2  <= r_sync1;
            r_prev   <= r_sync2;
            r_db_cnt <= w_db_cnt_next;
            if (!w_changed && (w_db_cnt_next == DB_LAST)) begin
                r_sensed <= r_sync2;
            end
        end
    end

    // Steering decision from the accepted vector; all-white holds until the line is lost.
    always_comb begin
        w_state_next = r_state;
        w_lost_next  = '0;
        case (r_sensed)
            3'b010, 3'b101: w_state_next = ST_FWD;
            3'b110:         w_state_next = ST_SOFT_L;
            3'b100:         w_state_next = ST_HARD_L;
            3'b011:         w_state_next = ST_SOFT_R;
            3'b001:         w_state_next = ST_HARD_R;
            3'b111:         w_state_next = ST_STOP;
            default: begin
                w_lost_next = (r_lost == LOST_MAX) ? r_lost : r_lost + LOST_W'(1);
                if (w_lost_next == LOST_MAX) begin
                    w_state_next = ST_STOP;
                end
            end
        endcase
    end

    // Wheel codes for the state the FSM is about to enter.
    always_comb begin
        w_dir_l_next = DIR_STOP;
        w_dir_r_next = DIR_STOP;
        case (w_state_next)
            ST_FWD: begin
                w_dir_l_next = DIR_CCW;
                w_dir_r_next = DIR_CW;
            end
            ST_SOFT_L: begin
                w_dir_l_next = DIR_STOP;
                w_dir_r_next = DIR_CW;
            end
            ST_HARD_L: begin
                w_dir_l_next = DIR_CW;
                w_dir_r_next = DIR_CW;
            end
            ST_SOFT_R: begin
                w_dir_l_next = DIR_CCW;
                w_dir_r_next = DIR_STOP;
            end
            ST_HARD_R: begin
                w_dir_l_next = DIR_CCW;
                w_dir_r_next = DIR_CCW;
            end
            default: begin
                w_dir_l_next = DIR_STOP;
                w_dir_r_next = DIR_STOP;
            end
        endcase
    end

    // FSM, lost counter and direction outputs advance only on the frame wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_STOP;
            r_lost  <= '0;
            r_dir_l <= DIR_STOP;
            r_dir_r <= DIR_STOP;
        end else if (w_wrap) begin
            r_state <= w_state_next;
            r_lost  <= w_lost_next;
            r_dir_l <= w_dir_l_next;
            r_dir_r <= w_dir_r_next;
        end
    end

endmodule

// File: tb/tb_line_drive_sequencer.sv
// Self-checking bench for line_drive_sequencer with a small frame
// (PERIOD=20, DEBOUNCE=4, LOST_FRAMES=3). A frame-level model predicts every
// output each cycle; directed literal checks pin the model at key points.
module tb_line_drive_sequencer;

    localparam int PERIOD      = 20;
    localparam int CNT_W       = 5;
    localparam int DEBOUNCE    = 4;
    localparam int LOST_FRAMES = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sensor_l = 1'b0;
    logic             sensor_m = 1'b0;
    logic             sensor_r = 1'b0;
    logic [CNT_W-1:0] count_out;
    logic             motor_reset;
    logic [1:0]       direction_l;
    logic [1:0]       direction_r;
    logic             frame_start;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    line_drive_sequencer #(
        .PERIOD      (PERIOD),
        .CNT_W       (CNT_W),
        .DEBOUNCE    (DEBOUNCE),
        .LOST_FRAMES (LOST_FRAMES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sensor_l    (sensor_l),
        .sensor_m    (sensor_m),
        .sensor_r    (sensor_r),
        .count_out   (count_out),
        .motor_reset (motor_reset),
        .direction_l (direction_l),
        .direction_r (direction_r),
        .frame_start (frame_start)
    );

    // Model state: frame position, pin sample history, accepted vector, wheel codes.
    int         m_cnt = 0;
    logic       m_fs = 1'b0;
    logic [2:0] m_hist [DEBOUNCE+2];
    logic [2:0] m_sensed = 3'b000;
    logic [1:0] m_dl = 2'b00;
    logic [1:0] m_dr = 2'b00;
    int         m_lost = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sensors(input logic [2:0] v);
        {sensor_l, sensor_m, sensor_r} = v;
    endtask

    // One clock of the model. A vector is accepted once it has been sampled on
    // DEBOUNCE consecutive edges, seen two edges late through the synchroniser.
    task automatic model_step();
        bit stable;
        if (reset) begin
            m_cnt = 0;
            m_fs = 1'b0;
            m_sensed = 3'b000;
            m_dl = 2'b00;
            m_dr = 2'b00;
            m_lost = 0;
            for (int i = 0; i < DEBOUNCE + 2; i++) m_hist[i] = 3'b000;
        end else begin
            if (m_cnt == PERIOD - 1) begin
                if (m_sensed == 3'b000) begin
                    if (m_lost < LOST_FRAMES) m_lost++;
                    if (m_lost >= LOST_FRAMES) begin
                        m_dl = 2'b00;
                        m_dr = 2'b00;
                    end
                end else begin
                    m_lost = 0;
                    case (m_sensed)
                        3'b010, 3'b101: begin m_dl = 2'b10; m_dr = 2'b01; end
                        3'b110:         begin m_dl = 2'b00; m_dr = 2'b01; end
                        3'b100:         begin m_dl = 2'b01; m_dr = 2'b01; end
                        3'b011:         begin m_dl = 2'b10; m_dr = 2'b00; end
                        3'b001:         begin m_dl = 2'b10; m_dr = 2'b10; end
                        default:        begin m_dl = 2'b00; m_dr = 2'b00; end
                    endcase
                end
                m_fs = 1'b1;
                m_cnt = 0;
            end else begin
                m_fs = 1'b0;
                m_cnt++;
            end
            for (int i = DEBOUNCE + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = {sensor_l, sensor_m, sensor_r};
            stable = 1'b1;
            for (int i = 3; i < DEBOUNCE + 2; i++) begin
                if (m_hist[i] != m_hist[2]) stable = 1'b0;
            end
            if (stable) m_sensed = m_hist[2];
        end
    endtask

    initial begin : model_proc
        for (int i = 0; i < DEBOUNCE + 2; i++) m_hist[i] = 3'b000;
        forever begin
            @(posedge clk or posedge reset);
            model_step();
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    initial begin : compare_proc
        forever begin
            @(negedge clk);
            check("count_out", 32'(count_out), 32'(m_cnt));
            check("motor_reset", 32'(motor_reset), 32'(reset || (m_cnt == PERIOD - 1)));
            check("frame_start", 32'(frame_start), 32'(m_fs));
            check("direction_l", 32'(direction_l), 32'(m_dl));
            check("direction_r", 32'(direction_r), 32'(m_dr));
        end
    end

    // Directed sequence; t counts clock edges since reset release.
    initial begin : stim_proc
        set_sensors(3'b000);
        tick(3);
        check("rst_count", 32'(count_out), 32'd0);
        check("rst_motor_reset", 32'(motor_reset), 32'd1);
        check("rst_dirs", 32'({direction_l, direction_r}), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("rel_count", 32'(count_out), 32'd0);
        check("rel_motor_reset", 32'(motor_reset), 32'd0);
        check("rel_frame_start", 32'(frame_start), 32'd0);

        // Sensors arrive late in frame 1, so the first wrap still sees 000.
        tick(16);                                      // t=16
        set_sensors(3'b010);
        tick(3);                                       // t=19
        check("last_count", 32'(count_out), 32'd19);
        check("last_motor_reset", 32'(motor_reset), 32'd1);
        tick(1);                                       // t=20
        check("wrap_count", 32'(count_out), 32'd0);
        check("wrap_frame_start", 32'(frame_start), 32'd1);
        tick(5);                                       // t=25
        check("first_wrap_dirs", 32'({direction_l, direction_r}), 32'b0000);
        tick(20);                                      // t=45
        check("fwd_dirs", 32'({direction_l, direction_r}), 32'b1001);

        // Three-cycle glitch on the right sensor never gets accepted.
        set_sensors(3'b011);
        tick(3);                                       // t=48
        set_sensors(3'b010);
        tick(17);                                      // t=65
        check("glitch_dirs_a", 32'({direction_l, direction_r}), 32'b1001);
        tick(20);                                      // t=85
        check("glitch_dirs_b", 32'({direction_l, direction_r}), 32'b1001);

        // Hard left held 10 cycles; back to centre before the wrap is sampled later.
        set_sensors(3'b100);
        tick(10);                                      // t=95
        set_sensors(3'b010);
        tick(10);                                      // t=105
        check("hard_l_dirs_a", 32'({direction_l, direction_r}), 32'b0101);
        tick(14);                                      // t=119
        check("hard_l_dirs_b", 32'({direction_l, direction_r}), 32'b0101);
        tick(6);                                       // t=125
        check("fwd_again_dirs", 32'({direction_l, direction_r}), 32'b1001);

        // Soft right, then lose the line: hold two wraps, stop on the third.
        set_sensors(3'b011);
        tick(20);                                      // t=145
        check("soft_r_dirs", 32'({direction_l, direction_r}), 32'b1000);
        set_sensors(3'b000);
        tick(20);                                      // t=165
        check("lost1_dirs", 32'({direction_l, direction_r}), 32'b1000);
        tick(20);                                      // t=185
        check("lost2_dirs", 32'({direction_l, direction_r}), 32'b1000);
        tick(20);                                      // t=205
        check("lost3_dirs", 32'({direction_l, direction_r}), 32'b0000);
        set_sensors(3'b010);
        tick(20);                                      // t=225
        check("recover_dirs", 32'({direction_l, direction_r}), 32'b1001);

        // Finish bar.
        set_sensors(3'b111);
        tick(20);                                      // t=245
        check("finish_dirs", 32'({direction_l, direction_r}), 32'b0000);

        // Hard right, then reset mid-frame at count 7.
        set_sensors(3'b001);
        tick(20);                                      // t=265
        check("hard_r_dirs", 32'({direction_l, direction_r}), 32'b1010);
        tick(2);                                       // t=267
        check("pre_reset_count", 32'(count_out), 32'd7);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_count", 32'(count_out), 32'd0);
        check("mid_rst_dirs", 32'({direction_l, direction_r}), 32'b0000);
        check("mid_rst_motor_reset", 32'(motor_reset), 32'd1);
        check("mid_rst_frame_start", 32'(frame_start), 32'd0);
        tick(3);
        #2 reset = 1'b0;
        #1;
        check("rerel_count", 32'(count_out), 32'd0);
        tick(19);                                      // t'=19
        check("rerel_last_count", 32'(count_out), 32'd19);
        check("rerel_dirs_before_wrap", 32'({direction_l, direction_r}), 32'b0000);
        tick(6);                                       // t'=25
        check("rerel_hard_r_dirs", 32'({direction_l, direction_r}), 32'b1010);
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
